wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//   Wishbone classic (B4, non-pipelined) bus master that turns single commands
//   from a valid/ready command port (fed from logic-analyzer pins or a debug
//   front end) into one read or write cycle toward a Wishbone slave such as the
//   user-project peripheral. Returns read data or a timeout error on a
//   valid/ready response port. This is the initiator end of the slave's bus.
// PARAMETERS
//   TIMEOUT_CYCLES  255  cycles in BUS state without ack before abort (0 = never)
//   CNT_W           16   width of the completed-transaction counter
// PORTS
//   wb_clk_i        in   1      single clock; all flops on rising edge
//   wb_rst_ni       in   1      reset, asynchronous assert, active-low
//   cmd_valid_i     in   1      command present
//   cmd_ready_o     out  1      command accepted when valid & ready
//   cmd_we_i        in   1      1 = write, 0 = read
//   cmd_adr_i       in   32     byte address
//   cmd_dat_i       in   32     write data
//   cmd_sel_i       in   4      byte selects
//   rsp_valid_o     out  1      response present
//   rsp_ready_i     in   1      response consumed when valid & ready
//   rsp_dat_o       out  32     read data (0 for writes and timeouts)
//   rsp_timeout_o   out  1      1 = cycle aborted by timeout
//   wbm_cyc_o       out  1      Wishbone CYC
//   wbm_stb_o       out  1      Wishbone STB
//   wbm_we_o        out  1      Wishbone WE
//   wbm_adr_o       out  32     Wishbone address
//   wbm_dat_o       out  32     Wishbone write data
//   wbm_sel_o       out  4      Wishbone byte selects
//   wbm_dat_i       in   32     Wishbone read data
//   wbm_ack_i       in   1      Wishbone ACK
//   txn_count_o     out  CNT_W  completed responses handed off (incl. timeouts)
// BEHAVIOUR
//   - Reset (wb_rst_ni=0, async): FSM=IDLE; every output 0 except cmd_ready_o=1.
//   - FSM IDLE -> BUS -> RESP -> IDLE; all outputs are registered.
//   - IDLE: cmd_ready_o=1. On accept, the next edge latches adr/dat/sel/we onto
//     wbm_*, sets cyc=stb=1, clears timeout counter, goes to BUS, ready->0.
//   - BUS: cyc/stb held with stable adr/dat/sel/we. Timeout counter increments
//     each BUS cycle without ack. On edge with wbm_ack_i=1: cyc=stb=0, rsp_dat_o
//     <= wbm_dat_i (read) or 0 (write), rsp_timeout_o=0, rsp_valid_o=1, -> RESP.
//     Minimum latency accept->rsp_valid = 2 cycles (ack in first BUS cycle).
//   - Timeout: counter reaching TIMEOUT_CYCLES with no ack: cyc=stb=0,
//     rsp_dat_o=0, rsp_timeout_o=1, rsp_valid_o=1, -> RESP. Ack sampled on that
//     same edge wins (normal completion). TIMEOUT_CYCLES=0: wait forever.
//   - RESP: rsp_* held stable until rsp_ready_i=1; on that edge rsp_valid_o=0,
//     txn_count_o += 1 (wraps at 2^CNT_W), -> IDLE, cmd_ready_o=1 next cycle.
//   - wbm_ack_i outside BUS is ignored (no state change, no counter change).
//   - wbm_we/adr/dat/sel are zeroed when cyc drops; no back-to-back cycles
//     (CYC always low for >=1 cycle between transactions).
//   - Reset mid-cycle aborts immediately: cyc/stb drop asynchronously, no
//     response issued, txn_count_o cleared.
// TESTING
//   1 write 0x3000_0004<=0xDEAD_BEEF sel=0xF, slave acks 1st cycle -> wbm_we=1,
//     cyc high 1 cycle, rsp_valid 2 cycles after accept, rsp_dat=0, timeout=0.
//   2 read 0x3000_0000, slave acks after 3 wait states with 0x1234_5678 ->
//     rsp_dat=0x1234_5678, count increments by 1 after rsp_ready.
//   3 TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles, rsp_timeout=1,
//     rsp_dat=0; late ack afterwards ignored.
//   4 ack on exactly the timeout edge -> normal completion, rsp_timeout=0.
//   5 rsp_ready held low 10 cycles, new cmd_valid pending -> rsp stable, cmd not
//     accepted until 1 cycle after rsp handshake; cyc low >=1 cycle between.
//   6 wb_rst_ni pulsed low during BUS -> cyc/stb/rsp_valid/txn_count all 0
//     immediately; after release cmd_ready=1 and next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic (B4) single-cycle bus master driven by a valid/ready command port.
// Each command becomes one read or write cycle; the result (or a timeout) returns on a valid/ready response port.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [3:0]       cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_timeout_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic [CNT_W-1:0] txn_count_o
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 4;
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    // Abort fires on the edge that ends the TIMEOUT_CYCLES-th BUS cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
    logic              rsp_to_q, rsp_to_d;
    logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
    logic              bus_ack_c;
    logic              bus_expire_c;

    // Ack on the expiry edge takes priority over the timeout.
    assign bus_ack_c    = (state_q == ST_BUS) && wbm_ack_i;
    assign bus_expire_c = (state_q == ST_BUS) && !wbm_ack_i && TO_EN && (to_cnt_q == TO_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_to_d    = rsp_to_q;
        txn_cnt_d   = txn_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    to_cnt_d    = '0;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_ack_c || bus_expire_c) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = bus_expire_c;
                    rsp_dat_d   = (bus_ack_c && !we_q) ? wbm_dat_i : '0;
                    state_d     = ST_RESP;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    txn_cnt_d   = txn_cnt_q + CNT_W'(1);
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_to_q    <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_to_q    <= rsp_to_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_timeout_o = rsp_to_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign wbm_sel_o     = sel_q;
    assign txn_count_o   = txn_cnt_q;

endmodule
